// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared types, constants and interval classifier for the S/PDIF biphase-mark receiver
// Contents: preamble_t, interval_t, slot counts, classify_interval().
package spdif_pkg;

    localparam int SUBFRAME_SLOTS = 32;
    localparam int DATA_SLOTS     = 28;
    localparam int AUDIO_BITS     = 24;

    typedef enum logic [1:0] {
        PRE_B = 2'd0,
        PRE_M = 2'd1,
        PRE_W = 2'd2
    } preamble_t;

    typedef enum logic [2:0] {
        IV_GLITCH  = 3'd0,
        IV_S       = 3'd1,
        IV_M       = 3'd2,
        IV_L       = 3'd3,
        IV_TIMEOUT = 3'd4
    } interval_t;

    // Thresholds are compared at twice the count so that odd multiples of
    // half a half-cell stay exact integers.
    function automatic interval_t classify_interval(input logic [7:0] count, input int half);
        int c2;
        c2 = 2 * int'(count);
        if (c2 < half)          return IV_GLITCH;
        else if (c2 < 3 * half) return IV_S;
        else if (c2 < 5 * half) return IV_M;
        else if (c2 < 7 * half) return IV_L;
        else                    return IV_TIMEOUT;
    endfunction

endpackage

// File: rtl/spdif_bmc_decoder_timer.sv
// rtl/spdif_bmc_decoder_timer.sv - synchronizer, edge detector and interval classifier (module bmc_interval_timer)
// Ports:
//   clk, rst      oversampling clock, asynchronous active-high reset
//   line          raw line input, asynchronous to clk
//   edge_valid    one-cycle strobe: an interval was classified or a timeout hit
//   interval      classification that goes with edge_valid
module bmc_interval_timer
    import spdif_pkg::*;
#(
    parameter int HALF_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      line,
    output logic      edge_valid,
    output interval_t interval
);

    localparam logic [7:0] LIM_TO = 8'(7 * HALF_CYCLES / 2);

    logic       sync1;
    logic       sync2;
    logic       dly;
    logic [7:0] count;
    logic       line_edge;
    logic       fire_timeout;

    assign line_edge = sync2 ^ dly;

    // Timeout fires on the single cycle the counter steps onto 7H/2; the
    // counter then keeps climbing (or saturates), so an idle line reports once.
    assign fire_timeout = !line_edge && (count == LIM_TO - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            dly        <= 1'b0;
            count      <= 8'd0;
            edge_valid <= 1'b0;
            interval   <= IV_GLITCH;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
            dly   <= sync2;

            if (line_edge)
                count <= 8'd1;
            else if (count != 8'hFF)
                count <= count + 8'd1;

            // An edge ending an over-long interval produces no event: its
            // timeout has already been reported.
            edge_valid <= (line_edge && (count < LIM_TO)) || fire_timeout;
            interval   <= line_edge ? classify_interval(count, HALF_CYCLES) : IV_TIMEOUT;
        end
    end

endmodule

// File: rtl/spdif_bmc_decoder.sv
// rtl/spdif_bmc_decoder.sv - S/PDIF biphase-mark receiver: preamble lock and subframe reassembly
// Ports:
//   clk, rst          oversampling clock, asynchronous active-high reset
//   spdif_in          raw optical line
//   audio_out         24-bit sample, slot 4 in bit 0
//   preamble_out      0=B, 1=M, 2=W
//   vucp_out          {V,U,C,P}
//   frame_valid_out   one-cycle strobe when a subframe completes
//   parity_err_out    odd parity over slots 4..31
//   locked_out        set by a parity-clean subframe, cleared by any error
//   err_out           one-cycle pulse on glitch, timeout or illegal interval
module spdif_bmc_decoder #(
    parameter int HALF_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spdif_in,
    output logic [23:0] audio_out,
    output logic [1:0]  preamble_out,
    output logic [3:0]  vucp_out,
    output logic        frame_valid_out,
    output logic        parity_err_out,
    output logic        locked_out,
    output logic        err_out
);

    import spdif_pkg::*;

    localparam logic [2:0] ST_HUNT   = 3'd0;
    localparam logic [2:0] ST_PRE1   = 3'd1;
    localparam logic [2:0] ST_PRE2   = 3'd2;
    localparam logic [2:0] ST_PRE3   = 3'd3;
    localparam logic [2:0] ST_DATA_A = 3'd4;
    localparam logic [2:0] ST_DATA_B = 3'd5;

    localparam logic [4:0] LAST_BIT = 5'(DATA_SLOTS - 1);

    logic                  iv_valid;
    interval_t             iv;
    logic [2:0]            state;
    logic [2:0]            state_n;
    interval_t             pre1;
    interval_t             pre2;
    preamble_t             cur_pre;
    preamble_t             pre_dec;
    logic                  pre_ok;
    logic                  do_shift;
    logic                  do_fail;
    logic                  last_bit;
    logic [DATA_SLOTS-1:0] shreg;
    logic [DATA_SLOTS-1:0] next_sr;
    logic [4:0]            bit_cnt;

    bmc_interval_timer #(
        .HALF_CYCLES(HALF_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .line       (spdif_in),
        .edge_valid (iv_valid),
        .interval   (iv)
    );

    // A shift from DATA_B is the second half of a '1'; from DATA_A it is a '0'.
    assign next_sr  = {state == ST_DATA_B, shreg[DATA_SLOTS-1:1]};
    assign last_bit = (bit_cnt == LAST_BIT);

    always_comb begin
        state_n  = state;
        do_shift = 1'b0;
        do_fail  = 1'b0;
        pre_ok   = 1'b0;
        pre_dec  = PRE_B;
        if (iv_valid) begin
            if (iv == IV_GLITCH || iv == IV_TIMEOUT) begin
                do_fail = 1'b1;
            end else begin
                case (state)
                    ST_HUNT: if (iv == IV_L) state_n = ST_PRE1;
                    ST_PRE1: state_n = ST_PRE2;
                    ST_PRE2: state_n = ST_PRE3;
                    ST_PRE3: begin
                        // The leading L was consumed by HUNT; match the other three.
                        if (pre1 == IV_S && pre2 == IV_S && iv == IV_L) begin
                            pre_ok  = 1'b1;
                            pre_dec = PRE_B;
                        end else if (pre1 == IV_L && pre2 == IV_S && iv == IV_S) begin
                            pre_ok  = 1'b1;
                            pre_dec = PRE_M;
                        end else if (pre1 == IV_M && pre2 == IV_S && iv == IV_M) begin
                            pre_ok  = 1'b1;
                            pre_dec = PRE_W;
                        end else begin
                            do_fail = 1'b1;
                        end
                        if (pre_ok) state_n = ST_DATA_A;
                    end
                    ST_DATA_A: begin
                        if (iv == IV_M)      do_shift = 1'b1;
                        else if (iv == IV_S) state_n  = ST_DATA_B;
                        else                 do_fail  = 1'b1;
                    end
                    ST_DATA_B: begin
                        if (iv == IV_S) do_shift = 1'b1;
                        else            do_fail  = 1'b1;
                    end
                    default: state_n = ST_HUNT;
                endcase
            end
            // After slot 31 the next interval must be a fresh preamble's L,
            // which is exactly what HUNT looks for.
            if (do_shift) state_n = last_bit ? ST_HUNT : ST_DATA_A;
            if (do_fail)  state_n = ST_HUNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_HUNT;
            pre1            <= IV_GLITCH;
            pre2            <= IV_GLITCH;
            cur_pre         <= PRE_B;
            shreg           <= '0;
            bit_cnt         <= 5'd0;
            audio_out       <= 24'd0;
            preamble_out    <= 2'd0;
            vucp_out        <= 4'd0;
            frame_valid_out <= 1'b0;
            parity_err_out  <= 1'b0;
            locked_out      <= 1'b0;
            err_out         <= 1'b0;
        end else begin
            frame_valid_out <= 1'b0;
            err_out         <= 1'b0;
            state           <= state_n;

            if (iv_valid && state == ST_PRE1) pre1 <= iv;
            if (iv_valid && state == ST_PRE2) pre2 <= iv;

            if (pre_ok) begin
                shreg   <= '0;
                bit_cnt <= 5'd0;
                cur_pre <= pre_dec;
            end

            if (do_shift) begin
                shreg   <= next_sr;
                bit_cnt <= bit_cnt + 5'd1;
                if (last_bit) begin
                    audio_out       <= next_sr[AUDIO_BITS-1:0];
                    vucp_out        <= {next_sr[24], next_sr[25], next_sr[26], next_sr[27]};
                    preamble_out    <= cur_pre;
                    parity_err_out  <= ^next_sr;
                    locked_out      <= ~(^next_sr);
                    frame_valid_out <= 1'b1;
                end
            end

            if (do_fail) begin
                err_out    <= 1'b1;
                locked_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spdif_bmc_decoder.sv
// tb/tb_spdif_bmc_decoder.sv - self-checking bench for spdif_bmc_decoder
module tb_spdif_bmc_decoder;

    localparam int H = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        spdif_in;
    logic [23:0] audio_out;
    logic [1:0]  preamble_out;
    logic [3:0]  vucp_out;
    logic        frame_valid_out;
    logic        parity_err_out;
    logic        locked_out;
    logic        err_out;

    always #5 clk = ~clk;

    spdif_bmc_decoder #(.HALF_CYCLES(H)) dut (
        .clk             (clk),
        .rst             (rst),
        .spdif_in        (spdif_in),
        .audio_out       (audio_out),
        .preamble_out    (preamble_out),
        .vucp_out        (vucp_out),
        .frame_valid_out (frame_valid_out),
        .parity_err_out  (parity_err_out),
        .locked_out      (locked_out),
        .err_out         (err_out)
    );

    typedef struct {
        logic [23:0] audio;
        logic [1:0]  pre;
        logic [3:0]  vucp;
        logic        perr;
        logic        lock;
        int          cyc;
    } rec_t;

    rec_t got[$];
    rec_t exp_q[$];
    int   runs[$];
    int   cyc = 0;
    int   errs = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(negedge clk) begin
        rec_t r;
        cyc++;
        if (!rst) begin
            if (frame_valid_out) begin
                r.audio = audio_out;
                r.pre   = preamble_out;
                r.vucp  = vucp_out;
                r.perr  = parity_err_out;
                r.lock  = locked_out;
                r.cyc   = cyc;
                got.push_back(r);
            end
            if (err_out) errs++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Subframe word as it sits on the wire: bit i is slot i+4, P makes slots 4..31 even.
    function automatic logic [27:0] mk_word(input logic [23:0] a, input logic v, input logic u,
                                            input logic c);
        logic p;
        p = ^{c, u, v, a};
        return {p, c, u, v, a};
    endfunction

    // Interval length in clocks; jitter keeps each interval inside its class window.
    function automatic int jl(input int halves, input int hc, input bit jit);
        int j;
        if (!jit) return halves * hc;
        j = (halves == 1) ? 4 : 6;
        return halves * hc + int'($urandom_range(2 * j)) - j;
    endfunction

    task automatic add_pre(input int p, input int hc, input bit jit);
        int seq[4];
        case (p)
            0:       seq = '{3, 1, 1, 3};
            1:       seq = '{3, 3, 1, 1};
            default: seq = '{3, 2, 1, 2};
        endcase
        foreach (seq[i]) runs.push_back(jl(seq[i], hc, jit));
    endtask

    task automatic add_frame(input int p, input logic [23:0] a, input logic [2:0] vuc,
                             input bit flip_p, input int hc, input bit jit, input int gslot,
                             input bit expect_it);
        logic [27:0] w;
        rec_t        e;
        w = mk_word(a, vuc[2], vuc[1], vuc[0]);
        if (flip_p) w[27] = ~w[27];
        add_pre(p, hc, jit);
        for (int i = 0; i < 28; i++) begin
            if (i == gslot) begin
                // Zero-valued cell split as 10 / 3 / 19 clocks: S, GLITCH, S.
                runs.push_back(10);
                runs.push_back(3);
                runs.push_back(2 * hc - 13);
            end else if (w[i]) begin
                runs.push_back(jl(1, hc, jit));
                runs.push_back(jl(1, hc, jit));
            end else begin
                runs.push_back(jl(2, hc, jit));
            end
        end
        if (expect_it) begin
            e.audio = w[23:0];
            e.pre   = 2'(p);
            e.vucp  = {w[24], w[25], w[26], w[27]};
            e.perr  = ^w;
            e.lock  = ~(^w);
            e.cyc   = 0;
            exp_q.push_back(e);
        end
    endtask

    // One toggle to open, then a toggle after each run.
    task automatic send_n(input int n);
        @(posedge clk);
        #1 spdif_in = ~spdif_in;
        for (int i = 0; i < n && i < runs.size(); i++) begin
            repeat (runs[i]) @(posedge clk);
            #1 spdif_in = ~spdif_in;
        end
        runs.delete();
    endtask

    task automatic send();
        send_n(runs.size());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_frames(input string tag);
        int n;
        chk({tag, ".count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d].audio", tag, i), got[i].audio, exp_q[i].audio);
            chk($sformatf("%s[%0d].pre", tag, i),   got[i].pre,   exp_q[i].pre);
            chk($sformatf("%s[%0d].vucp", tag, i),  got[i].vucp,  exp_q[i].vucp);
            chk($sformatf("%s[%0d].perr", tag, i),  got[i].perr,  exp_q[i].perr);
            chk($sformatf("%s[%0d].lock", tag, i),  got[i].lock,  exp_q[i].lock);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int          e0;
        logic [23:0] base;

        // Reset and idle line
        rst      = 1'b1;
        spdif_in = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst.audio", audio_out, 0);
        chk("rst.pre", preamble_out, 0);
        chk("rst.vucp", vucp_out, 0);
        chk("rst.valid", frame_valid_out, 0);
        chk("rst.perr", parity_err_out, 0);
        chk("rst.locked", locked_out, 0);
        chk("rst.err", err_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(200);
        chk("idle.err_pulses", errs, 1);
        chk("idle.strobes", got.size(), 0);
        chk("idle.audio", audio_out, 0);
        chk("idle.locked", locked_out, 0);

        // Single B subframe
        add_frame(0, 24'hA5A5A5, 3'b001, 1'b0, H, 1'b0, -1, 1'b1);
        e0 = errs;
        send();
        idle(20);
        chk("b.locked_live", locked_out, 1);
        chk("b.no_err", errs - e0, 0);
        compare_frames("b");
        idle(100);
        chk("b.tail_timeout", errs - e0, 1);
        chk("b.unlock_after_timeout", locked_out, 0);

        // Continuous M, W, B stream with incrementing samples
        base = 24'($urandom);
        for (int k = 0; k < 6; k++)
            add_frame((k + 1) % 3, base + 24'(k), 3'($urandom), 1'b0, H, 1'b0, -1, 1'b1);
        e0 = errs;
        send();
        idle(20);
        chk("cont.no_err", errs - e0, 0);
        for (int i = 1; i < got.size(); i++)
            chk($sformatf("cont.spacing%0d", i), got[i].cyc - got[i-1].cyc, 64 * H);
        compare_frames("cont");
        idle(100);

        // Parity error drops lock
        add_frame(0, 24'($urandom), 3'($urandom), 1'b0, H, 1'b0, -1, 1'b1);
        add_frame(1, 24'($urandom), 3'($urandom), 1'b1, H, 1'b0, -1, 1'b1);
        send();
        idle(20);
        chk("par.locked_live", locked_out, 0);
        compare_frames("par");
        idle(100);

        // Glitch in slot 10 of the middle subframe; the following one re-locks
        add_frame(0, 24'($urandom), 3'($urandom), 1'b0, H, 1'b0, -1, 1'b1);
        add_frame(1, 24'($urandom) & ~24'h40, 3'($urandom), 1'b0, H, 1'b0, 6, 1'b0);
        add_frame(2, 24'($urandom), 3'($urandom), 1'b0, H, 1'b0, -1, 1'b1);
        e0 = errs;
        send();
        idle(20);
        chk("glitch.err_pulses", errs - e0, 1);
        compare_frames("glitch");
        idle(100);

        // Interval jitter within the classification windows
        for (int k = 0; k < 3; k++)
            add_frame(k, 24'($urandom), 3'($urandom), 1'b0, H, 1'b1, -1, 1'b1);
        e0 = errs;
        send();
        idle(20);
        chk("jit.no_err", errs - e0, 0);
        compare_frames("jit");
        idle(100);

        // 7-clock half-cells are glitches
        add_frame(0, 24'($urandom), 3'($urandom), 1'b0, 7, 1'b0, -1, 1'b0);
        e0 = errs;
        send();
        idle(100);
        chk("short.err_seen", (errs - e0) > 0, 1);
        compare_frames("short");

        // Reset in the middle of a subframe
        add_frame(0, 24'($urandom), 3'($urandom), 1'b0, H, 1'b0, -1, 1'b0);
        send_n(30);
        rst      = 1'b1;
        spdif_in = 1'b0;
        idle(4);
        e0 = errs;
        rst = 1'b0;
        idle(200);
        chk("midrst.strobes", got.size(), 0);
        chk("midrst.err_pulses", errs - e0, 1);
        chk("midrst.locked", locked_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
